// File: rtl/spi_ram_host_seq.sv
// Host-side SPI master sequencer: one parallel byte request becomes two 10-bit SPI frames
// (cmd[1:0] + payload[7:0], MSB first), with the read byte captured from miso.
module spi_ram_host_seq #(
    parameter int GAP_CYCLES = 2,
    parameter int RD_LAT     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    // state      | meaning
    // S_IDLE     | waiting for a request, ss_n high
    // S_SEL      | ss_n low, slave command-check cycle
    // S_SHIFT    | 10 frame bits on mosi, MSB first
    // S_GAP      | ss_n held low for slave/RAM settle
    // S_RD_WAIT  | read frame1 only: RAM read latency
    // S_RD_SHIFT | read frame1 only: 8 miso samples, MSB first
    // S_DESEL    | ss_n high for one cycle between/after frames
    // S_RESP     | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SHIFT,
        S_GAP,
        S_RD_WAIT,
        S_RD_SHIFT,
        S_DESEL,
        S_RESP
    } state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] BIT_LD  = CW'(9);
    localparam logic [CW-1:0] BYTE_LD = CW'(7);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LAT_LD  = CW'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_q, frame_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ss_n_q, ss_n_d;
    logic          mosi_q, mosi_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;
    logic [9:0]    frame_word;

    // cmd[1] = read, cmd[0] = data frame; reads send a dummy zero byte in frame1
    always_comb begin
        frame_word = {~wr_q, frame_q, addr_q};
        if (frame_q) begin
            frame_word[7:0] = wr_q ? wdata_q : 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    frame_d = 1'b0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                state_d = S_SHIFT;
                cnt_d   = BIT_LD;
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (frame_q && !wr_q) begin
                        state_d = S_RD_WAIT;
                        cnt_d   = LAT_LD;
                    end else begin
                        state_d = S_DESEL;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RD_SHIFT;
                    cnt_d   = BYTE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RD_SHIFT: begin
                shift_d = {shift_q[6:0], miso};
                if (cnt_q == '0) begin
                    state_d = S_DESEL;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DESEL: begin
                if (!frame_q) begin
                    frame_d = 1'b1;
                    state_d = S_SEL;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q
        ss_n_d      = (state_d == S_IDLE) || (state_d == S_DESEL) || (state_d == S_RESP);
        mosi_d      = (state_d == S_SHIFT) ? frame_word[cnt_d[3:0]] : 1'b0;
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        rdata_d     = ((state_d == S_RESP) && !wr_q) ? shift_q : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            shift_q     <= 8'h00;
            rdata_q     <= 8'h00;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_ram_host_seq.sv
// Bench for spi_ram_host_seq: a behavioural SPI RAM slave on the serial pins plus a
// byte-array reference model of the RAM contents and frame/latency arithmetic.
module tb_spi_ram_host_seq;

    localparam int G = 2;
    localparam int L = 3;
    localparam int WR_LAT   = 2 * (12 + G) + 1;
    localparam int RD_LAT_T = (12 + G) + (20 + G + L) + 1;
    localparam int LEN_STD  = 11 + G;          // ss_n-low cycles of an ordinary frame
    localparam int LEN_RD1  = 19 + G + L;      // ss_n-low cycles of read frame1
    localparam int RD_START = 11 + G + L;      // low-cycle index of first miso bit

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_rsp = 0;
    int rsp_seen = 0;
    int mosi_bad = 0;
    logic [7:0] last_rd = 8'h00;

    logic [7:0] ref_mem   [256];
    logic [7:0] slave_mem [256];

    logic [9:0] fw_q[$];
    int         fl_q[$];
    int         fg_q[$];

    spi_ram_host_seq #(.GAP_CYCLES(G), .RD_LAT(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave model: observes mid-cycle, decodes frames, and drives read data on miso
    int         k_low = 0;
    int         k_high = 0;
    int         cur_gap = 0;
    logic [9:0] word = '0;
    logic [9:0] full;
    logic [7:0] s_addr = 8'h00;
    logic [7:0] rbyte = 8'h00;
    bit         rd_frame = 1'b0;

    always @(negedge clk) begin
        miso = 1'b0;
        if (!rst_n) begin
            k_low = 0;
            k_high = 0;
            word = '0;
            rd_frame = 1'b0;
        end else if (ss_n === 1'b0) begin
            if (k_low == 0) begin
                cur_gap = k_high;
                rd_frame = 1'b0;
            end
            if (k_low >= 1 && k_low <= 10) begin
                full = {word[8:0], mosi};
                word = full;
                if (k_low == 10) begin
                    case (full[9:8])
                        2'b00: s_addr = full[7:0];
                        2'b01: slave_mem[s_addr] = full[7:0];
                        2'b10: s_addr = full[7:0];
                        default: begin
                            rd_frame = 1'b1;
                            rbyte = slave_mem[s_addr];
                        end
                    endcase
                end
            end else if (mosi !== 1'b0) begin
                mosi_bad++;
            end
            if (rd_frame && k_low >= RD_START && k_low < RD_START + 8)
                miso = rbyte[7 - (k_low - RD_START)];
            k_low++;
        end else begin
            if (mosi !== 1'b0) mosi_bad++;
            if (k_low > 0) begin
                fw_q.push_back(word);
                fl_q.push_back(k_low);
                fg_q.push_back(cur_gap);
                k_low = 0;
                k_high = 0;
            end
            k_high++;
        end
        if (rsp_valid === 1'b1) rsp_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flush_frames();
        fw_q.delete();
        fl_q.delete();
        fg_q.delete();
    endtask

    // One request; returns at the negedge of the rsp_valid cycle
    task automatic do_txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input bit hold, input int pulse_at);
        int cyc;
        bit seen;
        logic [9:0] w;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_wait", req_ready, 1);
        @(posedge clk);
        exp_rsp++;
        if (wr) ref_mem[a] = d;
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            req_wr    = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
        end
        chk("busy_start", busy, 1);
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc <= 200) begin
            if (pulse_at > 0 && cyc == pulse_at) begin
                req_valid = 1'b1;
                req_wr    = 1'($urandom);
                req_addr  = 8'($urandom);
                req_wdata = 8'($urandom);
                chk("ready_busy", req_ready, 0);
            end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
                req_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("rsp_latency", cyc, wr ? WR_LAT : RD_LAT_T);
        chk("busy_rsp", busy, 1);
        if (!wr) last_rd = ref_mem[a];
        chk(wr ? "rdata_hold" : "rdata", rsp_rdata, last_rd);
        chk("frame_count", fw_q.size(), 2);
        if (fw_q.size() >= 2) begin
            w = fw_q.pop_front();
            chk("frame0_word", w, {wr ? 2'b00 : 2'b10, a});
            chk("frame0_len", fl_q.pop_front(), LEN_STD);
            chk("gap_txn_ge2", (fg_q.pop_front() >= 2), 1);
            w = fw_q.pop_front();
            chk("frame1_word", w, {wr ? 2'b01 : 2'b11, wr ? d : 8'h00});
            chk("frame1_len", fl_q.pop_front(), wr ? LEN_STD : LEN_RD1);
            chk("gap_frames", fg_q.pop_front(), 1);
        end
        flush_frames();
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            slave_mem[i] = 8'h00;
        end

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ss_n", ss_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed write then read of 0x3C
        do_txn(1'b1, 8'h3C, 8'hA5, 1'b0, 0);
        chk("ram_3c", slave_mem[8'h3C], 8'hA5);
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        do_txn(1'b0, 8'h3C, 8'h00, 1'b0, 0);
        chk("t3_rdata", rsp_rdata, 8'hA5);

        // Back-to-back with req_valid held high
        for (int i = 0; i < 256; i++) do_txn(1'b1, 8'(i), ~8'(i), 1'b1, 0);
        for (int i = 0; i < 256; i++) do_txn(1'b0, 8'(i), 8'h00, 1'b1, 0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-transaction pulses are ignored
        do_txn(1'b1, 8'h55, 8'h77, 1'b0, 5);
        do_txn(1'b0, 8'h55, 8'h00, 1'b0, 20);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            automatic bit wr = 1'($urandom);
            automatic logic [7:0] a = 8'($urandom);
            automatic logic [7:0] d = 8'($urandom);
            automatic int p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 26)) : 0;
            do_txn(wr, a, d, 1'($urandom), p);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during RD_SHIFT of a read
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 8'h3C;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (32) @(negedge clk);
        chk("pre_rst_ss_n", ss_n, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", ss_n, 1);
        chk("mid_rst_mosi", mosi, 0);
        chk("mid_rst_rdata", rsp_rdata, 8'h00);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rd = 8'h00;
        flush_frames();
        repeat (50) @(negedge clk);
        chk("no_rsp_after_rst", rsp_seen, exp_rsp);
        do_txn(1'b0, 8'h3C, 8'h00, 1'b0, 0);
        chk("post_rst_rdata", rsp_rdata, ref_mem[8'h3C]);

        repeat (5) @(negedge clk);
        chk("rsp_pulse_total", rsp_seen, exp_rsp);
        chk("mosi_idle_zero", mosi_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
